// File: rtl/uart_tx_gen_if.sv
// Producer-to-transmitter word handshake (active-low valid/ready).
// master: drives data_in/valid_n; slave: drives ready_n.
interface uart_tx_gen_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] data_in;
    logic                 valid_n;
    logic                 ready_n;

    modport master (
        output data_in,
        output valid_n,
        input  ready_n
    );

    modport slave (
        input  data_in,
        input  valid_n,
        output ready_n
    );
endinterface

// File: rtl/uart_tx_gen.sv
// Parametrised UART transmitter with a one-word holding register.
// Ports: clk, rst (sync, active-high), up (word handshake), tx, busy.
module uart_tx_gen #(
    parameter int DATA_BITS = 8,
    parameter int CDIV      = 2,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1,
    parameter int MSB_FIRST = 1
) (
    input  logic          clk,
    input  logic          rst,
    uart_tx_gen_if.slave  up,
    output logic          tx,
    output logic          busy
);

    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_tx_gen: DATA_BITS must be 5..9");
    end
    if (CDIV < 1) begin : g_bad_cdiv
        $error("uart_tx_gen: CDIV must be >= 1");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
        $error("uart_tx_gen: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
        $error("uart_tx_gen: STOP_BITS must be 1 or 2");
    end
    if (MSB_FIRST < 0 || MSB_FIRST > 1) begin : g_bad_order
        $error("uart_tx_gen: MSB_FIRST must be 0 or 1");
    end

    localparam int TW = (CDIV > 1) ? $clog2(CDIV) : 1;
    localparam int BW = $clog2(DATA_BITS + 1);

    localparam logic [TW-1:0] T_LAST = TW'(CDIV - 1);
    localparam logic [BW-1:0] D_LAST = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] S_LAST = BW'(STOP_BITS - 1);
    localparam logic          ODD    = (PARITY == 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PAR,
        S_STOP
    } state_t;

    state_t               state_q, state_d;
    logic [TW-1:0]        tmr_q, tmr_d;
    logic [BW-1:0]        cnt_q, cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic [DATA_BITS-1:0] hold_q, hold_d;
    logic                 hold_v_q, hold_v_d;
    logic                 tx_q, tx_d;
    logic                 busy_q, busy_d;

    logic ready_n;
    logic accept;
    logic load;
    logic tick;

    assign ready_n    = hold_v_q | rst;
    assign up.ready_n = ready_n;
    assign accept     = ~up.valid_n & ~ready_n;
    assign tx         = tx_q;
    assign busy       = busy_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shift_d  = shift_q;
        par_d    = par_q;
        hold_d   = hold_q;
        hold_v_d = hold_v_q;
        load     = 1'b0;
        tick     = (tmr_q == T_LAST);
        tmr_d    = tick ? '0 : tmr_q + 1'b1;

        unique case (state_q)
            S_IDLE: begin
                tmr_d = '0;
                if (hold_v_q) begin
                    load    = 1'b1;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (tick) begin
                    state_d = S_DATA;
                    cnt_d   = '0;
                end
            end
            S_DATA: begin
                if (tick) begin
                    if (cnt_q == D_LAST) begin
                        cnt_d   = '0;
                        state_d = (PARITY != 0) ? S_PAR : S_STOP;
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                        shift_d = (MSB_FIRST != 0) ? (shift_q << 1)
                                                   : (shift_q >> 1);
                    end
                end
            end
            S_PAR: begin
                if (tick) begin
                    state_d = S_STOP;
                    cnt_d   = '0;
                end
            end
            S_STOP: begin
                if (tick) begin
                    if (cnt_q == S_LAST) begin
                        cnt_d = '0;
                        // Reload straight into START: no idle gap.
                        if (hold_v_q) begin
                            load    = 1'b1;
                            state_d = S_START;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Accept and load are mutually exclusive: accept needs an
        // empty hold, load needs a full one.
        if (load) begin
            shift_d  = hold_q;
            par_d    = (^hold_q) ^ ODD;
            hold_v_d = 1'b0;
        end
        if (accept) begin
            hold_d   = up.data_in;
            hold_v_d = 1'b1;
        end

        // Line level is registered, so derive it from the next state.
        tx_d = 1'b1;
        unique case (state_d)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = (MSB_FIRST != 0) ? shift_d[DATA_BITS-1]
                                             : shift_d[0];
            S_PAR:   tx_d = par_d;
            default: tx_d = 1'b1;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            tmr_q    <= '0;
            cnt_q    <= '0;
            shift_q  <= '0;
            par_q    <= 1'b0;
            hold_q   <= '0;
            hold_v_q <= 1'b0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            tmr_q    <= tmr_d;
            cnt_q    <= cnt_d;
            shift_q  <= shift_d;
            par_q    <= par_d;
            hold_q   <= hold_d;
            hold_v_q <= hold_v_d;
            tx_q     <= tx_d;
            busy_q   <= busy_d;
        end
    end

endmodule
